icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 123 ++++++++++++
 tb/tb_icache.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per frame.
// Zero-latency hit in IDLE; a miss parks in FETCH until memory returns the word.
// Optional macro ICACHE_STATS_EN adds saturating hit/miss counters.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        inv,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state, state_nxt;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tags [SETS];
  logic [31:0]        data [SETS];
  logic [31:0]        miss_addr;
  logic               drop;

  logic [IDX_W-1:0]   idx, fill_idx;
  logic [TAG_W-1:0]   tag, fill_tag;
  logic               lookup_hit;
  logic               miss_start, fill_done, fill_wr;
  logic               unused_bits;

  assign idx        = imemaddr[IDX_W+1:2];
  assign tag        = imemaddr[31:IDX_W+2];
  assign fill_idx   = miss_addr[IDX_W+1:2];
  assign fill_tag   = miss_addr[31:IDX_W+2];
  assign lookup_hit = valid[idx] && (tags[idx] == tag);
  assign iaddr      = miss_addr;
  assign imemload   = ihit ? data[idx] : 32'h0;
  // byte-offset bits never participate in lookup or fill
  assign unused_bits = ^{imemaddr[1:0], miss_addr[1:0]};

  // next-state and handshake decode
  always_comb begin
    state_nxt  = state;
    ihit       = 1'b0;
    iREN       = 1'b0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    fill_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (imemREN && !inv) begin
          if (lookup_hit) begin
            ihit = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_nxt  = FETCH;
          end
        end
      end
      FETCH: begin
        iREN = 1'b1;
        if (!iwait) begin
          fill_done = 1'b1;
          // an invalidate seen during this fetch poisons the returning word
          fill_wr   = !inv && !drop;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control state: FSM, valid bits, drop flag, miss address
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      drop      <= 1'b0;
      miss_addr <= 32'h0;
    end else begin
      state <= state_nxt;
      if (inv)          valid <= '0;
      else if (fill_wr) valid[fill_idx] <= 1'b1;
      if (miss_start)   miss_addr <= {imemaddr[31:2], 2'b00};
      if (fill_done)                  drop <= 1'b0;
      else if (state == FETCH && inv) drop <= 1'b1;
    end
  end

  // tag/data arrays: no reset, written only by a completed fill
  always_ff @(posedge CLK) begin
    if (fill_wr && !RST) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // saturating hit/miss counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (ihit && hit_count != 32'hFFFF_FFFF)        hit_count  <= hit_count + 32'h1;
      if (miss_start && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache with a word-address-level reference model.
module tb_icache;
  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        RST, imemREN, inv, iwait;
  logic [31:0] imemaddr, iload;
  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache #(.SETS(SETS)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .inv(inv),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", t, obs, exp);
    end
  endtask

  // Reference model: each frame remembers which word address it holds.
  bit          m_vld  [SETS];
  logic [31:0] m_line [SETS];
  logic [31:0] m_data [SETS];
  bit          m_busy;       // a miss is outstanding at memory
  bit          m_poison;     // invalidate arrived while outstanding
  logic [31:0] m_addr;
  longint      m_hits, m_misses;

  // last sampled outputs for directed checks
  logic        o_hit, o_ren;
  logic [31:0] o_load, o_addr;

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  task automatic m_reset();
    foreach (m_vld[i]) m_vld[i] = 0;
    m_busy = 0; m_poison = 0; m_addr = 32'h0;
    m_hits = 0; m_misses = 0;
  endtask

  task automatic cycle(input bit ren, input logic [31:0] a, input bit iv,
                       input bit wt, input bit rs, input logic [31:0] ld);
    bit          e_hit;
    logic [31:0] e_load, wa;
    @(negedge CLK);
    imemREN = ren; imemaddr = a; inv = iv; iwait = wt; RST = rs; iload = ld;
    #1;
    wa     = {a[31:2], 2'b00};
    e_hit  = !m_busy && ren && !iv && m_vld[slot(a)] && m_line[slot(a)] == wa;
    e_load = e_hit ? m_data[slot(a)] : 32'h0;
    o_hit = ihit; o_load = imemload; o_ren = iREN; o_addr = iaddr;
    chk("ihit", {31'h0, ihit}, {31'h0, e_hit});
    chk("imemload", imemload, e_load);
    chk("iREN", {31'h0, iREN}, {31'h0, m_busy});
    chk("iaddr", iaddr, m_addr);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, (m_hits > 32'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(m_hits));
    chk("miss_count", miss_count, (m_misses > 32'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(m_misses));
`endif
    @(posedge CLK);
    if (rs) begin
      m_reset();
    end else if (!m_busy) begin
      if (e_hit) m_hits++;
      if (iv) foreach (m_vld[i]) m_vld[i] = 0;
      else if (ren && !e_hit) begin
        m_busy = 1; m_addr = wa; m_misses++;
      end
    end else begin
      if (iv) begin
        foreach (m_vld[i]) m_vld[i] = 0;
        m_poison = 1;
      end
      if (!wt) begin
        if (!iv && !m_poison) begin
          m_vld[slot(m_addr)]  = 1;
          m_line[slot(m_addr)] = m_addr;
          m_data[slot(m_addr)] = ld;
        end
        m_busy = 0; m_poison = 0;
      end
    end
  endtask

  // miss on addr, memory answers on the given fetch cycle
  task automatic fill(input logic [31:0] a, input int lat, input logic [31:0] ld);
    cycle(1, a, 0, 1, 0, 32'h0);
    for (int k = 1; k <= lat; k++) cycle(1, a, 0, (k != lat), 0, ld);
  endtask

  logic [31:0] pool [8] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h40, 32'h44, 32'h80, 32'hC0};

  initial begin
    int niren;
    RST = 1; imemREN = 0; imemaddr = 0; inv = 0; iwait = 1; iload = 0;
    repeat (2) @(posedge CLK);
    m_reset();

    // reset state
    cycle(0, 32'h40, 0, 1, 0, 32'h0);
    chk("rst_ihit", {31'h0, o_hit}, 32'h0);
    chk("rst_iaddr", o_addr, 32'h0);

    // cold miss, iwait low on third fetch cycle
    niren = 0;
    cycle(1, 32'h40, 0, 1, 0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1, 32'h40, 0, (k != 3), 0, 32'h8C220004);
      if (o_ren) niren++;
    end
    chk("cold_iren_cycles", niren, 3);
    chk("cold_iaddr", o_addr, 32'h40);
    cycle(1, 32'h40, 0, 1, 0, 32'h0);
    chk("cold_hit", {31'h0, o_hit}, 32'h1);
    chk("cold_load", o_load, 32'h8C220004);
    // repeat hit; iREN stays low
    cycle(1, 32'h42, 0, 1, 0, 32'h0);
    chk("hit_again", {31'h0, o_hit}, 32'h1);
    chk("hit_iren", {31'h0, o_ren}, 32'h0);

    // conflict on index 0
    fill(32'h80, 2, 32'hAAAA0080);
    cycle(1, 32'h40, 0, 1, 0, 32'h0);
    chk("conflict_evict", {31'h0, o_hit}, 32'h0);
    for (int k = 1; k <= 2; k++) cycle(1, 32'h40, 0, (k != 2), 0, 32'h11110040);

    // invalidate in IDLE
    fill(32'h00, 1, 32'h0);
    fill(32'h04, 1, 32'h4);
    cycle(0, 32'h00, 1, 1, 0, 32'h0);
    cycle(1, 32'h00, 0, 1, 0, 32'h0);
    chk("inv_miss0", {31'h0, o_hit}, 32'h0);
    cycle(1, 32'h00, 0, 0, 0, 32'h0);
    // invalidate during fetch of 0x08
    cycle(1, 32'h08, 0, 1, 0, 32'h0);
    cycle(1, 32'h08, 1, 1, 0, 32'h8);
    cycle(1, 32'h08, 0, 0, 0, 32'h8);
    cycle(1, 32'h08, 0, 1, 0, 32'h0);
    chk("inv_fetch_miss", {31'h0, o_hit}, 32'h0);
    cycle(1, 32'h08, 0, 0, 0, 32'h8);

    // reset mid-fetch
    cycle(1, 32'h10, 0, 1, 0, 32'h0);
    cycle(1, 32'h10, 0, 1, 1, 32'h10);
    cycle(1, 32'h10, 0, 1, 0, 32'h0);
    chk("rst_fetch_iren", {31'h0, o_ren}, 32'h0);
    chk("rst_fetch_hit", {31'h0, o_hit}, 32'h0);
    cycle(0, 32'h10, 0, 0, 0, 32'h0);

    // no request with a cached address
    fill(32'hC0, 1, 32'hC0C0C0C0);
    cycle(0, 32'hC0, 0, 1, 0, 32'h0);
    chk("noreq_hit", {31'h0, o_hit}, 32'h0);
    chk("noreq_load", o_load, 32'h0);
    cycle(1, 32'hC0, 0, 1, 0, 32'h0);
    chk("noreq_kept", {31'h0, o_hit}, 32'h1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? $urandom()
                                      : pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0, $urandom());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
